// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that serialises the instruction-fetch port
// and the load/store port onto one shared valid/ready memory bus. It keeps one
// transaction outstanding, times out a silent bus and raises a sticky error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_mask,
    input  logic              ls_wen,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    // shared memory bus
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    output logic              mem_wen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    // sticky timeout flag
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Owner / grant encoding: 0 = fetch, 1 = load/store.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Last counter value seen in WAIT before the abort fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               owner_r;
    logic               last_grant_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               grant_ls_s;
    logic               if_ready_s;
    logic               ls_ready_s;
    logic               accept_s;
    logic               resp_done_s;
    logic               timeout_s;

    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_wdata_r;
    logic [MASK_W-1:0]  mem_mask_r;
    logic               mem_wen_r;
    logic               if_resp_valid_r;
    logic               ls_resp_valid_r;
    logic [DATA_W-1:0]  if_rdata_r;
    logic [DATA_W-1:0]  ls_rdata_r;
    logic               err_r;

    // Round-robin grant: only offered in IDLE, a tie goes to the port not served last.
    always_comb begin
        grant_ls_s = 1'b0;
        if_ready_s = 1'b0;
        ls_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (if_req_valid && ls_req_valid) begin
                grant_ls_s = (last_grant_r == OWN_IF);
            end else begin
                grant_ls_s = ls_req_valid;
            end
            ls_ready_s = ls_req_valid && grant_ls_s;
            if_ready_s = if_req_valid && !grant_ls_s;
        end else begin
            grant_ls_s = 1'b0;
            if_ready_s = 1'b0;
            ls_ready_s = 1'b0;
        end
    end

    assign accept_s    = if_ready_s | ls_ready_s;
    assign resp_done_s = (state_r == ST_WAIT) && mem_resp_valid;
    // A response in the same cycle as the deadline takes precedence.
    assign timeout_s   = (state_r == ST_WAIT) && !mem_resp_valid && (cnt_r == CNT_LAST);

    // Next-state logic for the IDLE -> REQ -> WAIT transaction sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (resp_done_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request payload capture, timeout counter, response pulses and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r         <= OWN_IF;
            last_grant_r    <= OWN_LS;
            cnt_r           <= {CNT_W{1'b0}};
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wdata_r     <= {DATA_W{1'b0}};
            mem_mask_r      <= {MASK_W{1'b0}};
            mem_wen_r       <= 1'b0;
            if_resp_valid_r <= 1'b0;
            ls_resp_valid_r <= 1'b0;
            if_rdata_r      <= {DATA_W{1'b0}};
            ls_rdata_r      <= {DATA_W{1'b0}};
            err_r           <= 1'b0;
        end else begin
            if_resp_valid_r <= 1'b0;
            ls_resp_valid_r <= 1'b0;

            if (accept_s) begin
                owner_r      <= grant_ls_s;
                last_grant_r <= grant_ls_s;
                if (grant_ls_s) begin
                    mem_addr_r  <= ls_addr;
                    mem_wdata_r <= ls_wdata;
                    mem_mask_r  <= ls_mask;
                    mem_wen_r   <= ls_wen;
                end else begin
                    // Fetches are always plain reads.
                    mem_addr_r  <= if_addr;
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_mask_r  <= {MASK_W{1'b0}};
                    mem_wen_r   <= 1'b0;
                end
            end

            if ((state_r == ST_REQ) && mem_req_ready) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (resp_done_s || timeout_s) begin
                if (owner_r == OWN_LS) begin
                    ls_resp_valid_r <= 1'b1;
                    // Stores and aborted transfers return zero data.
                    if (resp_done_s && !mem_wen_r) begin
                        ls_rdata_r <= mem_rdata;
                    end else begin
                        ls_rdata_r <= {DATA_W{1'b0}};
                    end
                end else begin
                    if_resp_valid_r <= 1'b1;
                    if (resp_done_s) begin
                        if_rdata_r <= mem_rdata;
                    end else begin
                        if_rdata_r <= {DATA_W{1'b0}};
                    end
                end
            end

            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign if_req_ready  = if_ready_s;
    assign ls_req_ready  = ls_ready_s;
    assign mem_req_valid = (state_r == ST_REQ);
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_mask      = mem_mask_r;
    assign mem_wen       = mem_wen_r;
    assign if_resp_valid = if_resp_valid_r;
    assign ls_resp_valid = ls_resp_valid_r;
    assign if_rdata      = if_rdata_r;
    assign ls_rdata      = ls_rdata_r;
    assign err           = err_r;

endmodule
